// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed seven-segment scanner: raw glyphs
// ({g,f,e,d,c,b,a}, 1 = lit), FSM state type and a decimal range helper.
package seg_pkg;

  localparam logic [6:0] GLYPH_0     = 7'b0111111;
  localparam logic [6:0] GLYPH_1     = 7'b0000110;
  localparam logic [6:0] GLYPH_2     = 7'b1011011;
  localparam logic [6:0] GLYPH_3     = 7'b1001111;
  localparam logic [6:0] GLYPH_4     = 7'b1100110;
  localparam logic [6:0] GLYPH_5     = 7'b1101101;
  localparam logic [6:0] GLYPH_6     = 7'b1111101;
  localparam logic [6:0] GLYPH_7     = 7'b0000111;
  localparam logic [6:0] GLYPH_8     = 7'b1111111;
  localparam logic [6:0] GLYPH_9     = 7'b1101111;
  localparam logic [6:0] GLYPH_A     = 7'b1110111;
  localparam logic [6:0] GLYPH_B     = 7'b1111100;
  localparam logic [6:0] GLYPH_C     = 7'b0111001;
  localparam logic [6:0] GLYPH_D     = 7'b1011110;
  localparam logic [6:0] GLYPH_E     = 7'b1111001;
  localparam logic [6:0] GLYPH_F     = 7'b1110001;
  localparam logic [6:0] ERR_GLYPH   = 7'b1000000;
  localparam logic [6:0] BLANK_GLYPH = 7'b0000000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEX,
    ST_CONV,
    ST_COMMIT
  } state_e;

  // Largest value representable in n decimal digits.
  function automatic logic [63:0] pow10_m1(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

endpackage

// File: rtl/seg_glyph_lut.sv
// Maps one display digit to its raw segment pattern; error overrides blanking.
module seg_glyph_lut
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       blank_i,
  input  logic       err_i,
  output logic [6:0] raw_o
);

  always_comb begin
    raw_o = BLANK_GLYPH;
    if (err_i) begin
      raw_o = ERR_GLYPH;
    end else if (!blank_i) begin
      case (nibble_i)
        4'h0: raw_o = GLYPH_0;
        4'h1: raw_o = GLYPH_1;
        4'h2: raw_o = GLYPH_2;
        4'h3: raw_o = GLYPH_3;
        4'h4: raw_o = GLYPH_4;
        4'h5: raw_o = GLYPH_5;
        4'h6: raw_o = GLYPH_6;
        4'h7: raw_o = GLYPH_7;
        4'h8: raw_o = GLYPH_8;
        4'h9: raw_o = GLYPH_9;
        4'hA: raw_o = GLYPH_A;
        4'hB: raw_o = GLYPH_B;
        4'hC: raw_o = GLYPH_C;
        4'hD: raw_o = GLYPH_D;
        4'hE: raw_o = GLYPH_E;
        4'hF: raw_o = GLYPH_F;
        default: raw_o = BLANK_GLYPH;
      endcase
    end
  end

endmodule

// File: rtl/seg_display_scanner.sv
// Multi-digit seven-segment controller: load handshake, hex or double-dabble
// decimal conversion, atomic commit to display registers, time-multiplexed scan.
//   state  | meaning
//   IDLE   | ready, waiting for load
//   HEX    | copy nibbles into the result register
//   CONV   | one double-dabble step per cycle
//   COMMIT | write result, blanking and error flags to display registers
module seg_display_scanner
  import seg_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int BIN_W          = 16,
  parameter int CLK_DIV        = 50000,
  parameter int ACTIVE_LOW_SEG = 1,
  parameter int ACTIVE_LOW_AN  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [BIN_W-1:0]    bin_in,
  input  logic                hex_mode,
  input  logic                blank_lz,
  input  logic [N_DIGITS-1:0] dp_in,
  output logic                ready,
  output logic [6:0]          seg,
  output logic                dp,
  output logic [N_DIGITS-1:0] an
);

  localparam int   DW      = 4 * N_DIGITS;
  localparam int   HW      = (BIN_W < DW) ? BIN_W : DW;
  localparam int   IW      = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int   PW      = $clog2(CLK_DIV);
  localparam int   CW      = $clog2(BIN_W + 1);
  localparam logic SEG_INV = (ACTIVE_LOW_SEG != 0);
  localparam logic AN_INV  = (ACTIVE_LOW_AN != 0);

  state_e              state_q, state_d;
  logic [BIN_W-1:0]    bin_q, bin_d;
  logic [DW-1:0]       res_q, res_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                blank_q, blank_d;
  logic                ovf_q, ovf_d;
  logic [N_DIGITS-1:0] dpc_q, dpc_d;

  logic [DW-1:0]       disp_nib_q, disp_nib_d;
  logic [N_DIGITS-1:0] disp_blank_q, disp_blank_d;
  logic                disp_err_q, disp_err_d;
  logic [N_DIGITS-1:0] disp_dp_q, disp_dp_d;

  logic [PW-1:0]       pres_q;
  logic [IW-1:0]       idx_q;
  logic                tick, tick_q;
  logic [6:0]          seg_q;
  logic                dp_q;
  logic [N_DIGITS-1:0] an_q;

  logic [DW-1:0]       adj;
  logic [N_DIGITS-1:0] lz_blank;
  logic                all_zero;
  logic [6:0]          glyph_raw;

  always_comb begin
    adj = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      adj[4*i +: 4] = (res_q[4*i +: 4] >= 4'd5) ? res_q[4*i +: 4] + 4'd3 : res_q[4*i +: 4];
    end
  end

  // A digit is blanked when it and every digit above it are zero; digit 0 never is.
  always_comb begin
    lz_blank = '0;
    all_zero = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      all_zero = all_zero & (res_q[4*i +: 4] == 4'd0);
      if (i != 0) lz_blank[i] = blank_q & ~ovf_q & all_zero;
    end
  end

  always_comb begin
    state_d      = state_q;
    bin_d        = bin_q;
    res_d        = res_q;
    cnt_d        = cnt_q;
    blank_d      = blank_q;
    ovf_d        = ovf_q;
    dpc_d        = dpc_q;
    disp_nib_d   = disp_nib_q;
    disp_blank_d = disp_blank_q;
    disp_err_d   = disp_err_q;
    disp_dp_d    = disp_dp_q;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          bin_d   = bin_in;
          blank_d = blank_lz;
          dpc_d   = dp_in;
          ovf_d   = !hex_mode && (64'(bin_in) > pow10_m1(N_DIGITS));
          res_d   = '0;
          cnt_d   = CW'(BIN_W);
          state_d = hex_mode ? ST_HEX : ST_CONV;
        end
      end
      ST_HEX: begin
        res_d         = '0;
        res_d[HW-1:0] = bin_q[HW-1:0];
        state_d       = ST_COMMIT;
      end
      ST_CONV: begin
        if (cnt_q == '0) begin
          state_d = ST_COMMIT;
        end else begin
          res_d = {adj[DW-2:0], bin_q[BIN_W-1]};
          bin_d = bin_q << 1;
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_COMMIT: begin
        disp_nib_d   = res_q;
        disp_blank_d = lz_blank;
        disp_err_d   = ovf_q;
        disp_dp_d    = dpc_q;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign tick = (pres_q == PW'(CLK_DIV - 1));

  seg_glyph_lut u_lut (
    .nibble_i (disp_nib_q[4*idx_q +: 4]),
    .blank_i  (disp_blank_q[idx_q]),
    .err_i    (disp_err_q),
    .raw_o    (glyph_raw)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      bin_q        <= '0;
      res_q        <= '0;
      cnt_q        <= '0;
      blank_q      <= 1'b0;
      ovf_q        <= 1'b0;
      dpc_q        <= '0;
      disp_nib_q   <= '0;
      disp_blank_q <= '0;
      disp_err_q   <= 1'b0;
      disp_dp_q    <= '0;
      pres_q       <= '0;
      idx_q        <= IW'(N_DIGITS - 1);
      tick_q       <= 1'b0;
      seg_q        <= {7{SEG_INV}};
      dp_q         <= SEG_INV;
      an_q         <= {N_DIGITS{AN_INV}};
    end else begin
      state_q      <= state_d;
      bin_q        <= bin_d;
      res_q        <= res_d;
      cnt_q        <= cnt_d;
      blank_q      <= blank_d;
      ovf_q        <= ovf_d;
      dpc_q        <= dpc_d;
      disp_nib_q   <= disp_nib_d;
      disp_blank_q <= disp_blank_d;
      disp_err_q   <= disp_err_d;
      disp_dp_q    <= disp_dp_d;
      pres_q       <= tick ? '0 : pres_q + PW'(1);
      tick_q       <= tick;
      if (tick) idx_q <= (idx_q == IW'(N_DIGITS - 1)) ? '0 : idx_q + IW'(1);
      // Pins refresh only at slot start so a commit never changes a digit mid-slot.
      if (tick_q) begin
        seg_q <= glyph_raw ^ {7{SEG_INV}};
        dp_q  <= disp_dp_q[idx_q] ^ SEG_INV;
        an_q  <= (N_DIGITS'(1) << idx_q) ^ {N_DIGITS{AN_INV}};
      end
    end
  end

  assign ready = (state_q == ST_IDLE);
  assign seg   = seg_q;
  assign dp    = dp_q;
  assign an    = an_q;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Self-checking bench for seg_display_scanner: randomized loads compared
// against an arithmetic model of what each digit should show.
module tb_seg_display_scanner;

  localparam int N  = 4;
  localparam int BW = 16;
  localparam int CD = 4;

  localparam logic [6:0] GLYPH_TB [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load = 1'b0;
  logic [BW-1:0] bin_in = '0;
  logic          hex_mode = 1'b0;
  logic          blank_lz = 1'b0;
  logic [N-1:0]  dp_in = '0;
  logic          ready;
  logic [6:0]    seg;
  logic          dp;
  logic [N-1:0]  an;

  int n_run = 0;
  int n_fail = 0;

  int unsigned  m_val = 0;
  bit           m_hex = 1'b1;
  bit           m_blz = 1'b0;
  logic [N-1:0] m_dp = '0;

  seg_display_scanner #(
    .N_DIGITS(N), .BIN_W(BW), .CLK_DIV(CD), .ACTIVE_LOW_SEG(1), .ACTIVE_LOW_AN(1)
  ) dut (
    .clk(clk), .rst(rst), .load(load), .bin_in(bin_in), .hex_mode(hex_mode),
    .blank_lz(blank_lz), .dp_in(dp_in), .ready(ready), .seg(seg), .dp(dp), .an(an)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int unsigned pow10(input int k);
    int unsigned r = 1;
    for (int i = 0; i < k; i++) r = r * 10;
    return r;
  endfunction

  // Expected pin pattern (active low) for digit d of the modelled value.
  function automatic logic [6:0] exp_seg(input int d);
    int unsigned dig, above;
    if (!m_hex && m_val > pow10(N) - 1) return ~7'b1000000;
    if (m_hex) begin
      above = m_val >> (4 * d);
      dig   = above % 16;
    end else begin
      above = m_val / pow10(d);
      dig   = above % 10;
    end
    if (m_blz && d != 0 && above == 0) return 7'h7F;
    return ~GLYPH_TB[dig];
  endfunction

  function automatic int an_digit(input logic [N-1:0] a);
    int d = -1;
    for (int k = 0; k < N; k++) if (a === ~(N'(1) << k)) d = k;
    return d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int unsigned v, input bit h, input bit bz,
                         input logic [N-1:0] d, input string tag);
    int lat = 0;
    int exp_lat;
    exp_lat  = h ? 2 : BW + 2;
    bin_in   = v[BW-1:0];
    hex_mode = h;
    blank_lz = bz;
    dp_in    = d;
    load     = 1'b1;
    step();
    load = 1'b0;
    while (ready !== 1'b1 && lat < 100) begin
      step();
      lat++;
    end
    n_run++;
    if (lat != exp_lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d cycles, expected %0d", tag, lat, exp_lat);
    end
    m_val = v;
    m_hex = h;
    m_blz = bz;
    m_dp  = d;
  endtask

  // Observes one full scan: order, slot length, one-hot an, seg and dp per slot.
  task automatic check_display(input string tag);
    logic [N-1:0] prev;
    int wait_n;
    int d = 0;
    for (int s = 0; s < N; s++) begin
      prev = an;
      wait_n = 0;
      do begin
        step();
        wait_n++;
      end while (an === prev && wait_n < 3 * CD);
      if (s == 0) begin
        d = an_digit(an);
        n_run++;
        if (d < 0) begin
          n_fail++;
          $display("FAIL %s an_onehot: got %b", tag, an);
          d = 0;
        end
      end else begin
        d = (d + 1) % N;
        n_run++;
        if (an !== ~(N'(1) << d) || wait_n != CD) begin
          n_fail++;
          $display("FAIL %s scan: an=%b after %0d cycles, expected %b after %0d",
                   tag, an, wait_n, ~(N'(1) << d), CD);
        end
      end
      n_run++;
      if ({seg, dp} !== {exp_seg(d), ~m_dp[d]}) begin
        n_fail++;
        $display("FAIL %s digit%0d: seg=%b dp=%b, expected seg=%b dp=%b",
                 tag, d, seg, dp, exp_seg(d), ~m_dp[d]);
      end
    end
  endtask

  task automatic reset_pulse(input string tag);
    int lat = 0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_run++;
    if ({ready, seg, dp, an} !== {1'b1, 7'h7F, 1'b1, {N{1'b1}}}) begin
      n_fail++;
      $display("FAIL %s reset_vals: ready=%b seg=%b dp=%b an=%b, expected 1 1111111 1 %b",
               tag, ready, seg, dp, an, {N{1'b1}});
    end
    m_val = 0; m_hex = 1'b1; m_blz = 1'b0; m_dp = '0;
    while (an === {N{1'b1}} && lat < 20) begin
      step();
      lat++;
    end
    n_run++;
    if (lat != CD + 1 || an !== ~(N'(1)) || seg !== ~GLYPH_TB[0]) begin
      n_fail++;
      $display("FAIL %s first_slot: at cycle %0d an=%b seg=%b, expected cycle %0d an=%b seg=%b",
               tag, lat, an, seg, CD + 1, ~(N'(1)), ~GLYPH_TB[0]);
    end
    check_display({tag, "_zero"});
  endtask

  task automatic test_reset();
    step();
    reset_pulse("reset");
  endtask

  task automatic test_hex();
    do_load(16'hBEEF, 1'b1, 1'b0, '0, "hex_beef");
    check_display("hex_beef");
    for (int i = 0; i < 4; i++) begin
      do_load($urandom_range(0, 16'hFFFF), 1'b1, 1'($urandom_range(0, 1)),
              N'($urandom_range(0, 15)), "hex_rand");
      check_display("hex_rand");
    end
  endtask

  task automatic test_decimal();
    do_load(1234, 1'b0, 1'b0, '0, "dec_1234");
    check_display("dec_1234");
    for (int i = 0; i < 4; i++) begin
      do_load($urandom_range(0, 9999), 1'b0, 1'($urandom_range(0, 1)),
              N'($urandom_range(0, 15)), "dec_rand");
      check_display("dec_rand");
    end
  endtask

  task automatic test_overflow();
    do_load(10000, 1'b0, 1'b1, '0, "ovf_10000");
    check_display("ovf_10000");
    do_load(9999, 1'b0, 1'b0, '0, "dec_9999");
    check_display("dec_9999");
    do_load($urandom_range(10001, 16'hFFFF), 1'b0, 1'b0, N'($urandom_range(0, 15)), "ovf_rand");
    check_display("ovf_rand");
  endtask

  task automatic test_blanking();
    do_load(42, 1'b0, 1'b1, '0, "blank_42");
    check_display("blank_42");
    do_load(0, 1'b0, 1'b1, '0, "blank_0");
    check_display("blank_0");
    do_load(16'h00A0, 1'b1, 1'b1, '0, "blank_hex");
    check_display("blank_hex");
  endtask

  task automatic test_dp();
    do_load(5678, 1'b0, 1'b0, 4'b0100, "dp_digit2");
    check_display("dp_digit2");
  endtask

  task automatic test_busy_load();
    int lat;
    int d;
    do_load(1234, 1'b0, 1'b0, '0, "busy_old");
    bin_in = 16'd5678; hex_mode = 1'b0; blank_lz = 1'b0; dp_in = '0;
    load = 1'b1;
    step();
    load = 1'b0;
    lat = 0;
    repeat (3) begin step(); lat++; end
    bin_in = 16'd9; hex_mode = 1'b1; dp_in = '1;
    load = 1'b1;
    step();
    lat++;
    load = 1'b0;
    n_run++;
    if (ready !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_ready: got %b during conversion, expected 0", ready);
    end
    repeat (4) begin step(); lat++; end
    d = an_digit(an);
    n_run++;
    if (d < 0 || {seg, dp} !== {exp_seg(d), ~m_dp[d]}) begin
      n_fail++;
      $display("FAIL busy_old_display: an=%b seg=%b dp=%b during conversion", an, seg, dp);
    end
    while (ready !== 1'b1 && lat < 100) begin step(); lat++; end
    n_run++;
    if (lat != BW + 2) begin
      n_fail++;
      $display("FAIL busy_latency: got %0d cycles, expected %0d", lat, BW + 2);
    end
    m_val = 5678; m_hex = 1'b0; m_blz = 1'b0; m_dp = '0;
    check_display("busy_new");
  endtask

  task automatic test_rst_mid_conv();
    do_load(9876, 1'b0, 1'b0, 4'b1010, "rstconv_pre");
    bin_in = 16'd4321; hex_mode = 1'b0; blank_lz = 1'b0; dp_in = 4'b1111;
    load = 1'b1;
    step();
    load = 1'b0;
    repeat (5) step();
    reset_pulse("rst_conv");
  endtask

  initial begin
    test_reset();
    test_hex();
    test_decimal();
    test_overflow();
    test_blanking();
    test_dp();
    test_busy_load();
    test_rst_mid_conv();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_display_scanner.md
Name: seg_display_scanner

Overview:
Parametrised multi-digit seven-segment display controller; successor to the single-digit combinational decoder.
- Accepts a binary value through a load/ready handshake.
- Shows it either as hex nibbles or as decimal; decimal uses a sequential double-dabble BCD conversion.
- Time-multiplexes N_DIGITS common-anode/cathode digits, with optional leading-zero blanking and an overflow indication.
- Sits between core/debug registers and board display pins.

Parameters:
N_DIGITS, 4, number of multiplexed digits (1..8)
BIN_W, 16, width of bin_in (must satisfy BIN_W >= 4 and BIN_W <= 4*N_DIGITS for hex mode)
CLK_DIV, 50000, clock cycles per digit scan slot (>= 2)
ACTIVE_LOW_SEG, 1, 1 = seg/dp driven inverted (0 lights a segment)
ACTIVE_LOW_AN, 1, 1 = an driven inverted

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
load  in  1  request to capture bin_in; accepted when load && ready
bin_in  in  BIN_W  value to display
hex_mode  in  1  sampled on accept: 1 = hex, 0 = decimal
blank_lz  in  1  sampled on accept: 1 = blank leading zeros
dp_in  in  N_DIGITS  decimal points per digit, sampled on accept
ready  out  1  high when idle and able to accept a load
seg  out  7  segments {g,f,e,d,c,b,a}
dp  out  1  decimal point of the currently selected digit
an  out  N_DIGITS  one-hot digit enable

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - seg and dp are inactive: all 1 if ACTIVE_LOW_SEG, else 0.
  - an is all inactive.
  - ready = 1.
  - Display registers are cleared (digit value 0, no blank, no error, dp off).
  - Prescaler = 0 and digit index = N_DIGITS-1.
- FSM states: IDLE, HEX, CONV, COMMIT.
  - IDLE: ready = 1. On load && ready, capture bin_in, mode, blank_lz and dp_in; compute overflow = (hex_mode == 0 && bin_in > 10^N_DIGITS - 1).
  - Hex accept goes to HEX. Decimal accept goes to CONV with shift counter = BIN_W.
  - HEX: nibble i := bin_in[4i+3:4i], zero-extended for missing nibbles; go to COMMIT.
  - CONV: one double-dabble step per cycle on an N_DIGITS*4-bit BCD register (add 3 to each BCD digit >= 5, then shift left, bringing in the MSB of the remaining binary). After BIN_W steps go to COMMIT. BCD bits above N_DIGITS digits are discarded.
  - COMMIT: atomically write all display registers, then return to IDLE.
- Latency:
  - ready is low from the cycle after accept until back in IDLE.
  - Hex: 2 cycles accept-to-ready.
  - Decimal: BIN_W+2 cycles accept-to-ready.
  - New digits become visible from the first scan slot after COMMIT.
- load while ready = 0 is ignored (no queueing).
- Overflow: every digit shows ERR_GLYPH (segment g only). dp_in is still honoured. Blanking does not apply.
- Leading-zero blanking: digits above the most significant nonzero digit have all segments off. Digit 0 is never blanked, so value 0 shows "0". dp still follows dp_in.
- Scan:
  - The prescaler counts 0..CLK_DIV-1 and pulses tick at wrap.
  - On tick, the index advances with wrap (N_DIGITS-1 -> 0).
  - seg, dp and an are registered and update in the same cycle, one cycle after tick. They are never skewed.
  - The first tick after reset selects digit 0, and outputs first go active at cycle CLK_DIV+1.
- Scanning continues uninterrupted during CONV from the old display registers, so there is no glitch.
- Glyphs:
  - 0-9 use the standard pattern set.
  - A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001.
  - Raw patterns are inverted iff ACTIVE_LOW_SEG.
- rst mid-CONV: aborts immediately and applies all reset values; the partial result is never committed.

Decomposition:
- Package seg_pkg contains:
  - the glyph constants (GLYPH_0..GLYPH_F, ERR_GLYPH, BLANK_GLYPH);
  - the FSM state enum;
  - a function computing 10^N-1.
- One sub-module, seg_glyph_lut: combinational; inputs nibble, blank, err; output 7-bit raw pattern.
- The double-dabble step stays inline in the top module.

Test Plan:
- Hex mode: N=4, CLK_DIV=4; load 0xBEEF, hex_mode=1 -> ready low for 2 cycles; an cycles digits 0..3 every 4 cycles; seg shows F,E,E,b (digit 0 = F), inverted.
- Decimal: load 1234, hex_mode=0 -> ready returns high exactly 18 cycles after accept; digits 0..3 show 4,3,2,1.
- Overflow: decimal load 10000 -> all four digits show ERR_GLYPH (~7'b1000000 at the pins). Decimal load 9999 shows 9,9,9,9.
- Blanking: decimal load 42 with blank_lz=1 -> digits 3 and 2 have all segments off, digits 1 and 0 show 4 and 2. Load 0 -> only digit 0 lit, showing "0".
- Handshake and reset:
  - A second load during CONV is ignored, and the display keeps the old value until COMMIT.
  - Asserting rst at CONV step 5 -> next cycle ready=1 and seg/an are inactive; after the first tick digit 0 shows "0".
- dp and scan alignment: dp_in=4'b0100 -> dp is active only while an selects digit 2, asserted in the same cycle as an.
